// File: rtl/fetch_pkg.sv
// Shared constants, buffer entry type and PC helpers for the fetch stage.
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: DEPTH entries (power of two), flush, full/empty flags.
// Push into a full buffer is accepted when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output fetch_entry_t  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: credit-limited request issue, in-order response buffer, redirect flush with discard.
// Optional macro FETCH_BYPASS_EN: a response arriving to an empty buffer is presented the same cycle.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = CW + 2;

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_discard;

    logic          w_accept;
    logic          w_resp;
    logic          w_keep;
    logic          w_bypass;
    logic          w_inst_valid;
    logic          w_deq;
    logic          w_pop;
    logic          w_push;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [UW-1:0] w_used;
    fetch_entry_t  w_head;
    fetch_entry_t  w_resp_entry;

    // A response with nothing outstanding can only be a stale pre-reset beat.
    assign w_resp       = imem_resp_valid && (r_out_cnt != '0);
    assign w_keep       = w_resp && (r_discard == '0) && !redirect_valid;
    assign w_resp_entry = '{pc: r_resp_pc, inst: imem_resp_data};

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_keep && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_inst_valid = !redirect_valid && (!w_fifo_empty || w_bypass);
    assign w_deq        = w_inst_valid && inst_ready;
    assign w_pop        = w_deq && !w_fifo_empty;
    assign w_push       = w_keep && !(w_bypass && inst_ready) && (!w_fifo_full || w_pop);

    // Credits freed by this cycle's dequeue count immediately, giving one fetch per cycle.
    assign w_used         = UW'(r_out_cnt) + UW'(w_fifo_count) - UW'(w_deq);
    assign imem_req_valid = resetn && !redirect_valid && (w_used < UW'(DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign inst_valid     = w_inst_valid;

    always_comb begin
        inst    = NOP_INST;
        inst_pc = '0;
        if (w_inst_valid) begin
            if (w_fifo_empty) begin
                inst    = w_resp_entry.inst;
                inst_pc = w_resp_entry.pc;
            end else begin
                inst    = w_head.inst;
                inst_pc = w_head.pc;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_resp_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // r_resp_pc tracks the address of the next kept response; responses return in order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= pc_align(RESET_PC);
            r_resp_pc <= pc_align(RESET_PC);
            r_out_cnt <= '0;
            r_discard <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(w_resp);
            if (redirect_valid) begin
                r_pc      <= pc_align(redirect_pc);
                r_resp_pc <= pc_align(redirect_pc);
                r_discard <= r_out_cnt - CW'(w_resp);
            end else begin
                if (w_accept) r_pc <= pc_next(r_pc);
                if (w_keep)   r_resp_pc <= pc_next(r_resp_pc);
                if (w_resp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: in-order memory model with programmable latency, directed scenarios.
`timescale 1ns/1ps
module tb_fetch;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    int          cyc   = 0;
    int          lat   = 1;
    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] resp_addr = '0;
    logic [31:0] exp_e;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_stream(input logic [31:0] s);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(s + 32'(4 * i));
    endtask

    task automatic do_redirect(input logic [31:0] t, input logic [31:0] aligned);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        push_stream(aligned);
        acc_q.delete();
        #1;
        check("redir_req_withdrawn", imem_req_valid, 32'd0);
        check("redir_inst_valid_low", inst_valid, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
    endtask

    // Memory model: log accepts, retire the presented head.
    always @(negedge clk) begin
        if (resetn) begin
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{imem_req_addr, cyc + lat});
                acc_q.push_back(imem_req_addr);
            end
            if (imem_resp_valid && mem_q.size() > 0) mem_q.delete(0);
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (resetn && mem_q.size() > 0 && cyc >= mem_q[0].due) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdata(mem_q[0].addr);
            resp_addr       = mem_q[0].addr;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    // Monitor: every consumed instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (resetn) begin
            if (inst_valid && inst_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc %h want none", inst_pc);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("pop_pc", inst_pc, exp_e);
                    check("pop_inst", inst, mdata(exp_e));
                end
            end else if (!inst_valid) begin
                check("idle_inst_nop", inst, NOP_INST);
                check("idle_inst_pc", inst_pc, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int p0;
        int n;
        logic hit;

        resetn         = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        check("reset_req_valid", imem_req_valid, 32'd0);
        check("reset_inst_valid", inst_valid, 32'd0);
        check("reset_inst", inst, NOP_INST);
        check("reset_inst_pc", inst_pc, 32'd0);
        repeat (3) @(posedge clk);
        #2;

        // Release, 1-cycle memory, decode always ready
        push_stream(32'h0);
        acc_q.delete();
        resetn = 1'b1;
        #1;
        check("release_req_valid", imem_req_valid, 32'd1);
        check("release_req_addr", imem_req_addr, 32'h0);
        repeat (3) step();
        check("req0_addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h0);
        check("req1_addr", acc_q.size() > 1 ? acc_q[1] : 32'hDEAD_BEEF, 32'h4);
        check("req2_addr", acc_q.size() > 2 ? acc_q[2] : 32'hDEAD_BEEF, 32'h8);
        p0 = pops;
        repeat (4) step();
        check("steady_one_per_cycle", 32'(pops - p0), 32'd4);

        // Decode stall: credits cap issue, then drain without loss
        a0 = acc_q.size();
        inst_ready = 1'b0;
        repeat (10) step();
        check("stall_issue_le_depth", 32'((acc_q.size() - a0) <= DEPTH), 32'd1);
        check("stall_req_valid_low", imem_req_valid, 32'd0);
        check("stall_inst_valid", inst_valid, 32'd1);
        check("stall_head_pc", inst_pc, exp_q[0]);
        p0 = pops;
        inst_ready = 1'b1;
        repeat (12) step();
        check("drain_pops", 32'(pops - p0), 32'd12);

        // Redirect with two outstanding requests
        lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (mem_q.size() == 2 && !imem_resp_valid) hit = 1'b1;
        end
        check("wait_two_outstanding", 32'(hit), 32'd1);
        do_redirect(32'h0000_1003, 32'h0000_1000);
        p0 = pops;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("post_redirect_addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h0000_1000);
        repeat (15) step();
        check("post_redirect_progress", 32'(pops > p0), 32'd1);

        // Redirect coincident with a response and a ready decode
        lat = 1;
        repeat (6) step();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (imem_resp_valid && inst_valid) hit = 1'b1;
            else step();
        end
        check("wait_resp_and_valid", 32'(hit), 32'd1);
        p0 = pops;
        do_redirect(32'h0000_2000, 32'h0000_2000);
        check("coincident_no_pop", 32'(pops - p0), 32'd0);
        check("coincident_inst_valid_next", inst_valid, 32'd0);
        check("coincident_req_next_valid", imem_req_valid, 32'd1);
        check("coincident_req_next_addr", imem_req_addr, 32'h0000_2000);

        // Memory backpressure holds the request
        repeat (4) step();
        imem_req_ready = 1'b0;
        do_redirect(32'h0000_0020, 32'h0000_0020);
        for (int i = 0; i < 5; i++) begin
            check("hold_req_valid", imem_req_valid, 32'd1);
            check("hold_req_addr", imem_req_addr, 32'h0000_0020);
            step();
        end
        imem_req_ready = 1'b1;
        step();
        check("hold_accept_addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h0000_0020);

        // PC wrap and first-response latency into an empty buffer
        repeat (4) step();
        do_redirect(32'hFFFF_FFFF, 32'hFFFF_FFFC);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (imem_resp_valid && resp_addr == 32'hFFFF_FFFC) hit = 1'b1;
            else step();
        end
        check("wait_wrap_resp", 32'(hit), 32'd1);
`ifdef FETCH_BYPASS_EN
        check("bypass_same_cycle_valid", inst_valid, 32'd1);
        check("bypass_same_cycle_pc", inst_pc, 32'hFFFF_FFFC);
`else
        check("buffered_same_cycle_valid", inst_valid, 32'd0);
        step();
        check("buffered_next_cycle_valid", inst_valid, 32'd1);
        check("buffered_next_cycle_pc", inst_pc, 32'hFFFF_FFFC);
`endif
        repeat (3) step();
        check("wrap_addr0", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_addr1", acc_q.size() > 1 ? acc_q[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Reset in the middle of traffic
        lat = 2;
        repeat (3) step();
        resetn = 1'b0;
        mem_q.delete();
        imem_resp_valid = 1'b0;
        #1;
        check("midreset_req_valid", imem_req_valid, 32'd0);
        check("midreset_inst_valid", inst_valid, 32'd0);
        check("midreset_inst", inst, NOP_INST);
        check("midreset_inst_pc", inst_pc, 32'd0);
        repeat (2) step();
        push_stream(32'h0);
        acc_q.delete();
        p0 = pops;
        resetn = 1'b1;
        #1;
        check("rerelease_req_valid", imem_req_valid, 32'd1);
        check("rerelease_req_addr", imem_req_addr, 32'h0);
        repeat (10) step();
        check("rerelease_first_addr", acc_q.size() > 0 ? acc_q[0] : 32'hDEAD_BEEF, 32'h0);
        check("rerelease_progress", 32'(pops > p0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
